// File: rtl/com_uart_rx_os.sv
// Oversampling UART receiver with a frame FIFO read through a valid/ready port.
// Optional macro COM_UART_RX_MAJORITY_EN: each sample is a 2-of-3 vote around mid-bit.
module com_uart_rx_os #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W_MAX = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  os_tick,
    input  logic                  rx_port,
    input  logic [1:0]            data_bit_config,
    input  logic [1:0]            parity_bit_config,
    input  logic                  stop_bit_config,
    output logic [DATA_W_MAX-1:0] rx_data,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_W_MAX > 1) ? $clog2(DATA_W_MAX) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W_MAX + 2;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
`ifdef COM_UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] DEC_PT = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] MAJ_A  = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] MAJ_B  = TW'(OVERSAMPLE / 2 - 1);
`else
    localparam logic [TW-1:0] DEC_PT = TW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_STOP2, ST_DONE
    } state_t;

    function automatic logic xor_reduce(input logic [DATA_W_MAX-1:0] d);
        return ^d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t                state_r, state_s;
    logic                  sync1_r, rxs_r;
    logic [TW-1:0]         tick_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [BW-1:0]         last_bit_s;
    logic [DATA_W_MAX-1:0] data_r;
    logic                  par_err_r, frm_err_r, armed_r;
    logic [1:0]            cfg_data_r, cfg_par_r;
    logic                  cfg_stop_r;
    logic                  samp_ev_s, samp_bit_s, push_s;

    logic [EW-1:0]         mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic                  full_s, pop_s, wr_en_s, ovr_s, head_avail_s;
    logic [DATA_W_MAX-1:0] rx_data_r;
    logic                  rx_parity_err_r, rx_frame_err_r, rx_valid_r, overrun_r, busy_r;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx_port;
            rxs_r   <= sync1_r;
        end
    end

`ifdef COM_UART_RX_MAJORITY_EN
    logic maj_a_r, maj_b_r;

    // Capture the two samples preceding the decision tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_a_r <= 1'b1;
            maj_b_r <= 1'b1;
        end else if (os_tick && (tick_cnt_r == MAJ_A)) begin
            maj_a_r <= rxs_r;
        end else if (os_tick && (tick_cnt_r == MAJ_B)) begin
            maj_b_r <= rxs_r;
        end
    end

    assign samp_bit_s = maj3(maj_a_r, maj_b_r, rxs_r);
`else
    assign samp_bit_s = rxs_r;
`endif

    assign samp_ev_s  = os_tick && (tick_cnt_r == DEC_PT);
    assign last_bit_s = BW'(3'd4) + BW'(cfg_data_r);

    // Next-state logic; DONE is a single clk that pushes the frame
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (os_tick && armed_r && !rxs_r) state_s = ST_START;
                else                              state_s = ST_IDLE;
            end
            ST_START: begin
                if (samp_ev_s) state_s = samp_bit_s ? ST_IDLE : ST_DATA;
                else           state_s = ST_START;
            end
            ST_DATA: begin
                if (samp_ev_s && (bit_cnt_r == last_bit_s))
                    state_s = cfg_par_r[1] ? ST_PARITY : ST_STOP;
                else
                    state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (samp_ev_s) state_s = ST_STOP;
                else           state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (samp_ev_s) state_s = cfg_stop_r ? ST_STOP2 : ST_DONE;
                else           state_s = ST_STOP;
            end
            ST_STOP2: begin
                if (samp_ev_s) state_s = ST_DONE;
                else           state_s = ST_STOP2;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                push_s  = 1'b1;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Tick-gated frame datapath; armed_r demands a high line before a new start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            data_r     <= '0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            armed_r    <= 1'b0;
            cfg_data_r <= 2'd0;
            cfg_par_r  <= 2'd0;
            cfg_stop_r <= 1'b0;
        end else if (os_tick) begin
            if (state_r == ST_IDLE)
                tick_cnt_r <= '0;
            else if (tick_cnt_r == TICK_LAST)
                tick_cnt_r <= '0;
            else
                tick_cnt_r <= tick_cnt_r + TW'(1'b1);
            case (state_r)
                ST_IDLE: begin
                    if (rxs_r) begin
                        armed_r <= 1'b1;
                    end else if (armed_r) begin
                        armed_r    <= 1'b0;
                        cfg_data_r <= data_bit_config;
                        cfg_par_r  <= parity_bit_config;
                        cfg_stop_r <= stop_bit_config;
                        bit_cnt_r  <= '0;
                        data_r     <= '0;
                        par_err_r  <= 1'b0;
                        frm_err_r  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (samp_ev_s) begin
                        data_r    <= data_r | (DATA_W_MAX'(samp_bit_s) << bit_cnt_r);
                        bit_cnt_r <= bit_cnt_r + BW'(1'b1);
                    end
                end
                ST_PARITY: begin
                    if (samp_ev_s)
                        par_err_r <= samp_bit_s != (xor_reduce(data_r) ^ cfg_par_r[0]);
                end
                ST_STOP, ST_STOP2: begin
                    if (samp_ev_s && !samp_bit_s) frm_err_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pointer MSB distinguishes full from empty
    assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s        = rx_valid_r && rx_ready;
    assign wr_en_s      = push_s && (!full_s || pop_s);
    assign ovr_s        = push_s && full_s && !pop_s;
    assign rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(pop_s);
    assign head_avail_s = (wr_ptr_r != rd_ptr_nxt_s);

    // FIFO storage; flushed through the pointers on reset
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= {data_r, par_err_r, frm_err_r};
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            rd_ptr_r <= rd_ptr_nxt_s;
        end
    end

    // Registered head and status outputs; head holds its last value when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r       <= '0;
            rx_parity_err_r <= 1'b0;
            rx_frame_err_r  <= 1'b0;
            rx_valid_r      <= 1'b0;
            overrun_r       <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            rx_valid_r <= head_avail_s;
            if (head_avail_s)
                {rx_data_r, rx_parity_err_r, rx_frame_err_r} <= mem_r[rd_ptr_nxt_s[AW-1:0]];
            overrun_r <= ovr_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign rx_data       = rx_data_r;
    assign rx_parity_err = rx_parity_err_r;
    assign rx_frame_err  = rx_frame_err_r;
    assign rx_valid      = rx_valid_r;
    assign overrun       = overrun_r;
    assign busy          = busy_r;

endmodule
